// File: rtl/updown_pkg.sv
// Shared types and constants for the up/down bounce-sequence monitor.
package updown_pkg;

  // Default width of the monitored counter value.
  localparam int unsigned W_DEFAULT = 3;

  // Monitor FSM states with a fixed 2-bit encoding.
  typedef enum logic [1:0] {
    ST_INIT = 2'b00,  // nothing sampled since reset
    ST_ACQ  = 2'b01,  // one reference value held, direction unknown
    ST_UP   = 2'b10,  // tracking an ascending run
    ST_DOWN = 2'b11   // tracking a descending run
  } state_t;

  // Largest value a w-bit counter reaches before it turns around.
  function automatic int unsigned max_of(input int unsigned w);
    return (1 << w) - 1;
  endfunction

endpackage : updown_pkg

// File: rtl/onehot_decoder.sv
// Registered W -> 2^W one-hot decoder with load enable.
module onehot_decoder
  import updown_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [W-1:0]      val,
  output logic [2**W-1:0]   onehot
);

  localparam int unsigned N = 2**W;
  localparam logic [N-1:0] LSB_ONE = N'(1);

  // Load one-hot(val) when enabled; hold otherwise.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    if (reset) begin
      onehot <= '0;
    end else if (en) begin
      onehot <= LSB_ONE << val;
    end
  end

endmodule : onehot_decoder

// File: rtl/updown_seq_monitor.sv
// Checks that a sampled counter follows the 0..MAX..0 +/-1 bounce sequence,
// and reports direction, position, round trips and violation status.
module updown_seq_monitor
  import updown_pkg::*;
#(
  parameter int unsigned W     = W_DEFAULT,
  parameter int unsigned RT_W  = 8,
  parameter int unsigned ERR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_en,
  input  logic [W-1:0]      q_in,
  output logic              locked,
  output logic              dir_up,
  output logic [2**W-1:0]   led,
  output logic [RT_W-1:0]   round_trips,
  output logic              err_pulse,
  output logic              err_sticky,
  output logic [ERR_W-1:0]  err_count
);

  localparam logic [W-1:0]     MAX_V   = W'(max_of(W));
  localparam logic [W-1:0]     ZERO_V  = '0;
  localparam logic [W-1:0]     ONE_V   = W'(1);
  localparam logic [ERR_W-1:0] ERR_SAT = '1;

  state_t       state, state_nxt;
  logic [W-1:0] prev;
  logic         dir_nxt;
  logic         violation;
  logic         rt_inc;

  // Position display: one-hot of every accepted sample.
  onehot_decoder #(.W(W)) u_led_dec (
    .clk    (clk),
    .reset  (reset),
    .en     (sample_en),
    .val    (q_in),
    .onehot (led)
  );

  // Next-state, direction and violation decision for the current sample.
  // prev +/- 1 is only compared under guards that keep it inside 0..MAX.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_nxt = state;
    dir_nxt   = dir_up;
    violation = 1'b0;
    rt_inc    = 1'b0;

    if (sample_en) begin
      unique case (state)
        ST_INIT: begin
          state_nxt = ST_ACQ;
        end

        ST_ACQ: begin
          if (prev != MAX_V && q_in == prev + ONE_V) begin
            state_nxt = ST_UP;
            dir_nxt   = 1'b1;
          end else if (prev != ZERO_V && q_in == prev - ONE_V) begin
            state_nxt = ST_DOWN;
            dir_nxt   = 1'b0;
          end else begin
            violation = 1'b1;
          end
        end

        ST_UP: begin
          if (prev != MAX_V) begin
            if (q_in != prev + ONE_V) violation = 1'b1;
          end else if (q_in == MAX_V - ONE_V) begin
            state_nxt = ST_DOWN;
            dir_nxt   = 1'b0;
          end else begin
            violation = 1'b1;
          end
        end

        ST_DOWN: begin
          if (prev != ZERO_V) begin
            if (q_in != prev - ONE_V) violation = 1'b1;
          end else if (q_in == ONE_V) begin
            // Only the bottom turn while descending completes a round trip.
            state_nxt = ST_UP;
            dir_nxt   = 1'b1;
            rt_inc    = 1'b1;
          end else begin
            violation = 1'b1;
          end
        end

        default: state_nxt = ST_INIT;
      endcase

      // Any violation drops back to acquisition on the offending value.
      if (violation) state_nxt = ST_ACQ;
    end
  end

  // State, reference value and all registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_INIT;
      prev        <= '0;
      locked      <= 1'b0;
      dir_up      <= 1'b1;
      round_trips <= '0;
      err_pulse   <= 1'b0;
      err_sticky  <= 1'b0;
      err_count   <= '0;
    end else begin
      state     <= state_nxt;
      locked    <= (state_nxt == ST_UP) || (state_nxt == ST_DOWN);
      dir_up    <= dir_nxt;
      err_pulse <= violation;
      if (sample_en) prev <= q_in;
      if (rt_inc) round_trips <= round_trips + RT_W'(1);
      if (violation) begin
        err_sticky <= 1'b1;
        if (err_count != ERR_SAT) err_count <= err_count + ERR_W'(1);
      end
    end
  end

endmodule : updown_seq_monitor

// File: doc/updown_seq_monitor.md
Name: updown_seq_monitor

Overview:
- Downstream consumer of the 3-bit bouncing up/down counter (0→7→0 ping-pong, reversal at the end values).
- Samples the counter value and checks that it follows the legal ±1 bounce sequence.
- Reports direction, a one-hot position display, a completed round-trip count and error status.
- Feeds board LEDs and the debug/status logic.

Parameters:
- W, 3: width of the monitored count; MAX = 2^W-1.
- RT_W, 8: round-trip counter width; wraps modulo 2^RT_W.
- ERR_W, 4: error counter width; saturates at all-ones.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- sample_en  input  1  q_in is sampled on this cycle; when low, all state holds.
- q_in  input  W  counter value from the up/down counter.
- locked  output  1  monitor is tracking a known direction (state UP or DOWN).
- dir_up  output  1  current tracked direction: 1 = up, 0 = down.
- led  output  2^W  one-hot of the last sampled value: led[q] = 1.
- round_trips  output  RT_W  count of completed 0→MAX→0 cycles.
- err_pulse  output  1  one-cycle pulse on a sequence violation.
- err_sticky  output  1  set on the first violation, cleared only by reset.
- err_count  output  ERR_W  saturating violation count.

Behaviour:
- Single clock domain; reset is synchronous and active-high.
- All outputs are registered. Each result appears on the edge that samples q_in (one-cycle latency from sample_en high).
- Reset values:
  - state = INIT, prev = 0, locked = 0, dir_up = 1
  - led = 0, round_trips = 0
  - err_pulse = 0, err_sticky = 0, err_count = 0
- Reset asserted mid-operation: at the next edge all of the above is restored and the current sample is ignored.
- sample_en = 0: state, prev, led and counters hold; err_pulse = 0.
- On every accepted sample v: led ← one-hot(v), prev ← v.
- FSM states: INIT, ACQ, UP, DOWN. locked = (state ∈ {UP, DOWN}).
- INIT, first sample:
  - → ACQ.
  - No error is raised.
- ACQ, with prev p, infers direction from the second sample:
  - p < MAX and v = p+1 → UP, dir_up = 1.
  - p > 0 and v = p-1 → DOWN, dir_up = 0.
  - Otherwise: violation, stay in ACQ.
- UP, with prev p:
  - p < MAX: expect v = p+1, stay UP.
  - p = MAX: expect v = MAX-1, → DOWN, dir_up = 0.
- DOWN, with prev p:
  - p > 0: expect v = p-1, stay DOWN.
  - p = 0: expect v = 1, → UP, dir_up = 1, round_trips += 1 (wraps).
- Violation in UP or DOWN (v ≠ expected):
  - err_pulse = 1 for that cycle.
  - err_sticky ← 1.
  - err_count += 1, saturating at 2^ERR_W-1.
  - state → ACQ; prev ← v (resynchronise on the bad value).
- Violations in ACQ are handled identically (pulse, sticky, count); state stays ACQ.
- Repeated value (v = p) is a violation in every state except INIT.
- Wrap-around: MAX→0 or 0→MAX jumps are violations. The counter never wraps.
- A round trip is counted only on the DOWN-state 0→1 turn. The initial 0→1 from ACQ is not counted.
- Width rules:
  - p+1 and p-1 are evaluated only under the guards above, so no W-bit overflow is relied on.
  - led index is q_in zero-extended.

Decomposition:
- Shared package `updown_pkg` holds:
  - the state enum (INIT, ACQ, UP, DOWN) and its 2-bit encoding;
  - the constants W_DEFAULT = 3 and MAX(W).
- One natural sub-module: `onehot_decoder` (W → 2^W, registered enable), instantiated for led.
- Sequence checking and the counters stay in the top module.

Test Plan:
- Reset, then feed the reference sequence 0,1,…,7,6,…,0,1 with sample_en = 1 every cycle:
  - locked = 1 after the sample 1;
  - dir_up = 0 after the sample 6;
  - round_trips = 1 after the final 1;
  - err_sticky = 0; led tracks each value one-hot (e.g. led = 8'h80 at 7).
- Start mid-stream at 5,4,3:
  - after 5: state ACQ, locked = 0;
  - after 4: locked = 1, dir_up = 0;
  - no error.
- Inject a violation in UP: stream 2,3,5,6:
  - err_pulse high for exactly the cycle sampling 5;
  - err_count = 1, err_sticky = 1;
  - after 6: locked = 1, dir_up = 1.
- Toggle sample_en with 3,X(en=0),4:
  - outputs hold during the disabled cycle;
  - 3→4 is accepted with no error.
- Feed 16 repeated values 7,7,…:
  - err_count saturates at 15;
  - err_pulse fires on every one after the first.
- Assert reset for one cycle mid-DOWN (round_trips = 2, err_sticky = 1):
  - at the next edge all outputs return to reset values;
  - the following sample 0 enters ACQ.
